mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port ALU_resultM  input  32  effective address, or result for non-memory ops.
REQ-004 SHALL have port w_dataM  input  32  store data.
REQ-005 SHALL have ports rdM (input, 5) and pcplus4M (input, 32), carried to W unchanged.
REQ-006 SHALL have ports reg_writeM (input, 1), mem_writeM (input, 1) and result_srcM (input, 2); result_srcM = 2'b01 means load.
REQ-007 SHALL have port funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have bus outputs mem_req (1), mem_we (1), mem_addr (32), mem_wdata (32) and mem_be (4).
REQ-009 SHALL have bus inputs mem_rdata (32) and mem_ack (1).
REQ-010 SHALL have port stallM  output  1  holds the EM register and all earlier stages.
REQ-011 SHALL have registered outputs ALU_resultW (32), read_dataW (32), rdW (5), pcplus4W (32), reg_writeW (1), result_srcW (2) and misalign_errW (1).

Function
REQ-012 SHALL treat the M-stage op as a memory op when mem_writeM=1 or result_srcM=2'b01; any other op is a non-memory op.
REQ-013 SHALL use a two-state FSM, IDLE and BUS.
REQ-014 Non-memory op in IDLE SHALL: keep stallM=0; load ALU_resultW, rdW, pcplus4W, reg_writeW and result_srcW at the next edge; latency 1 cycle.
REQ-015 Memory op in IDLE SHALL: drive stallM=1 combinationally; go to BUS at the next edge; load a bubble into W (reg_writeW=0, misalign_errW=0).
REQ-016 In BUS SHALL drive mem_req=1, mem_we=mem_writeM and mem_addr={ALU_resultM[31:2],2'b00}; all three stay stable until mem_ack=1.
REQ-017 In BUS with mem_ack=0 SHALL hold stallM=1 and load a bubble into W each cycle.
REQ-018 In BUS with mem_ack=1 SHALL: drive stallM=0 that cycle; load the W registers (read_dataW from formatted mem_rdata for loads); return to IDLE at the edge.
REQ-019 Minimum memory-op latency SHALL be 2 cycles: IDLE, then BUS with ack; each extra wait cycle adds one.
REQ-020 mem_be and mem_wdata SHALL follow access size:
  - SB: mem_be = 4'b0001<<addr[1:0], mem_wdata = byte replicated x4.
  - SH: mem_be = 4'b0011<<(2*addr[1]), mem_wdata = halfword replicated x2.
  - SW: mem_be = 4'b1111, mem_wdata = w_dataM.
REQ-021 Loads SHALL select the byte/halfword from mem_rdata by addr[1:0]; B/H sign-extend to 32 bits; BU/HU zero-extend; W passes through.
REQ-022 mem_ack SHALL be ignored in IDLE; mem_req=0, mem_we=0 and mem_be=0 SHALL hold in IDLE.
REQ-023 Store completion SHALL leave reg_writeW equal to reg_writeM, 0 for a legal store.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear every W output to 0.
REQ-025 Reset during BUS SHALL abandon the access; mem_req is low in the first cycle after the reset edge; no W update from that access.

Configuration
REQ-026 With LSU_MISALIGN_TRAP_EN defined, an H/HU access with addr[0]=1 or a W access with addr[1:0]!=0 SHALL:
  - issue no bus request; no stall;
  - set misalign_errW=1 and reg_writeW=0 for 1 cycle.
REQ-027 Without LSU_MISALIGN_TRAP_EN, misalign_errW SHALL be tied 0; misaligned accesses SHALL proceed, lane selection using the address low bits as given.

Verification
REQ-028 ADD op, ALU_resultM=0x10, rdM=5, reg_writeM=1 -> next cycle ALU_resultW=0x10, rdW=5, reg_writeW=1; stallM never 1.
REQ-029 SB addr 0x103, w_dataM=0xAB, ack 1st BUS cycle -> mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xABABABAB; stallM=1 for exactly 1 cycle.
REQ-030 LB addr 0x102, mem_rdata=0x00800000, ack after 3 wait cycles -> stallM=1 for 4 cycles; read_dataW=0xFFFFFF80; LBU gives 0x00000080.
REQ-031 rst=1 in 2nd BUS cycle of a load -> mem_req=0 next cycle, all W outputs 0, FSM IDLE.
REQ-032 With LSU_MISALIGN_TRAP_EN, LW addr 0x102 -> mem_req never 1, misalign_errW=1 one cycle, reg_writeW=0, stallM=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//   Memory-stage load/store unit of the pipeline. Non-memory ops pass through
//   to the W registers in one cycle. Loads and stores stall the pipeline for
//   one IDLE cycle and then run a request/acknowledge bus transaction in BUS
//   until mem_ack arrives. Store lanes and data are replicated by access
//   size, and load data is aligned and sign- or zero-extended.
//
// Optional feature:
//   LSU_MISALIGN_TRAP_EN - when defined, a misaligned H/HU/W access issues no
//   bus request and no stall. It retires as a one-cycle misalign_errW with
//   reg_writeW=0. When undefined, misalign_errW is constant 0 and misaligned
//   accesses go to the bus using the address low bits as given.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   ALU_resultM           effective address, or result for non-memory ops
//   w_dataM               store data
//   rdM, pcplus4M         carried through to W
//   reg_writeM            register write enable of the M-stage op
//   mem_writeM            store indicator
//   result_srcM           2'b01 marks a load
//   funct3M               access size/sign (B, H, W, BU, HU)
//   mem_req/we/addr/wdata/be   data bus request side
//   mem_rdata, mem_ack    data bus response side
//   stallM                holds the EM register and all earlier stages
//   *W                    registered write-back stage outputs
// ---------------------------------------------------------------------------
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_resultM,
    input  logic [31:0] w_dataM,
    input  logic [4:0]  rdM,
    input  logic [31:0] pcplus4M,
    input  logic        reg_writeM,
    input  logic        mem_writeM,
    input  logic [1:0]  result_srcM,
    input  logic [2:0]  funct3M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stallM,
    output logic [31:0] ALU_resultW,
    output logic [31:0] read_dataW,
    output logic [4:0]  rdW,
    output logic [31:0] pcplus4W,
    output logic        reg_writeW,
    output logic [1:0]  result_srcW,
    output logic        misalign_errW
);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t state;

    logic        is_load;
    logic        is_mem;
    logic        misalign;
    logic        trap;
    logic [3:0]  size_be;
    logic [31:0] load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Operation classification
    always_comb begin
        is_load = (result_srcM == 2'b01);
        is_mem  = mem_writeM | is_load;
        misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((funct3M[1:0] == 2'b01) && ALU_resultM[0]) ||
                   ((funct3M == 3'b010) && (ALU_resultM[1:0] != 2'b00));
`endif
        // A trapped access never leaves IDLE, so the trap only applies there.
        trap = is_mem && misalign && (state == IDLE);
    end

    // Stall: the IDLE cycle of a bus access, and every BUS cycle without ack.
    always_comb begin
        stallM = 1'b0;
        if (state == IDLE)
            stallM = is_mem && !misalign;
        else
            stallM = !mem_ack;
    end

    // Store lane enables and replicated write data by access size
    always_comb begin
        size_be   = 4'b1111;
        mem_wdata = w_dataM;
        case (funct3M[1:0])
            2'b00: begin
                size_be   = 4'b0001 << ALU_resultM[1:0];
                mem_wdata = {4{w_dataM[7:0]}};
            end
            2'b01: begin
                size_be   = 4'b0011 << {ALU_resultM[1], 1'b0};
                mem_wdata = {2{w_dataM[15:0]}};
            end
            default: begin
                size_be   = 4'b1111;
                mem_wdata = w_dataM;
            end
        endcase
    end

    // Bus request side; the EM register is held while in BUS, so these
    // stay stable until mem_ack.
    always_comb begin
        mem_addr = {ALU_resultM[31:2], 2'b00};
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_be   = '0;
        if (state == BUS) begin
            mem_req = 1'b1;
            mem_we  = mem_writeM;
            mem_be  = size_be;
        end
    end

    // Load lane selection and extension
    always_comb begin
        case (ALU_resultM[1:0])
            2'b00:   load_byte = mem_rdata[7:0];
            2'b01:   load_byte = mem_rdata[15:8];
            2'b10:   load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = ALU_resultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3M[1:0])
            2'b00: begin
                if (funct3M[2])
                    load_data = {24'h000000, load_byte};
                else
                    load_data = {{24{load_byte[7]}}, load_byte};
            end
            2'b01: begin
                if (funct3M[2])
                    load_data = {16'h0000, load_half};
                else
                    load_data = {{16{load_half[15]}}, load_half};
            end
            default: load_data = mem_rdata;
        endcase
    end

    // FSM and W registers. A bubble clears reg_writeW and misalign_errW
    // while the remaining W fields hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ALU_resultW   <= '0;
            read_dataW    <= '0;
            rdW           <= '0;
            pcplus4W      <= '0;
            reg_writeW    <= 1'b0;
            result_srcW   <= '0;
            misalign_errW <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem && !trap) begin
                        state         <= BUS;
                        reg_writeW    <= 1'b0;
                        misalign_errW <= 1'b0;
                    end else begin
                        ALU_resultW   <= ALU_resultM;
                        rdW           <= rdM;
                        pcplus4W      <= pcplus4M;
                        result_srcW   <= result_srcM;
                        reg_writeW    <= trap ? 1'b0 : reg_writeM;
                        misalign_errW <= trap;
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        state         <= IDLE;
                        ALU_resultW   <= ALU_resultM;
                        rdW           <= rdM;
                        pcplus4W      <= pcplus4M;
                        result_srcW   <= result_srcM;
                        reg_writeW    <= reg_writeM;
                        misalign_errW <= 1'b0;
                        if (is_load)
                            read_dataW <= load_data;
                    end else begin
                        reg_writeW    <= 1'b0;
                        misalign_errW <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_resultM, w_dataM, pcplus4M, mem_rdata;
    logic [4:0]  rdM;
    logic        reg_writeM, mem_writeM, mem_ack;
    logic [1:0]  result_srcM;
    logic [2:0]  funct3M;
    logic        mem_req, mem_we, stallM;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ALU_resultW, read_dataW, pcplus4W;
    logic [4:0]  rdW;
    logic        reg_writeW, misalign_errW;
    logic [1:0]  result_srcW;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .ALU_resultM(ALU_resultM), .w_dataM(w_dataM), .rdM(rdM),
        .pcplus4M(pcplus4M), .reg_writeM(reg_writeM), .mem_writeM(mem_writeM),
        .result_srcM(result_srcM), .funct3M(funct3M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stallM(stallM),
        .ALU_resultW(ALU_resultW), .read_dataW(read_dataW), .rdW(rdW),
        .pcplus4W(pcplus4W), .reg_writeW(reg_writeW),
        .result_srcW(result_srcW), .misalign_errW(misalign_errW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        regw;
        logic [1:0]  rsrc;
        logic        mis;
    } w_rec_t;

    w_rec_t      sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] rd_hold  = '0;
    int          op_num   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] sh;
        logic [31:0] r;
        sh = d >> (8 * a[1:0]);
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'h0, sh[7:0]};
            3'b001:  r = a[1] ? {{16{d[31]}}, d[31:16]} : {{16{d[15]}}, d[15:0]};
            3'b101:  r = a[1] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return (lo == 2'd0) ? 4'b0001 : (lo == 2'd1) ? 4'b0010 :
                            (lo == 2'd2) ? 4'b0100 : 4'b1000;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {w[7:0], w[7:0], w[7:0], w[7:0]};
            2'b01:   return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store. Called at posedge+1.
    task automatic run_op(input int kind, input logic [2:0] f3, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [31:0] rdat, input int waits);
        w_rec_t e;
        w_rec_t g;
        int     stalls = 0;
        int     nbus   = 0;
        logic   st;
        logic   ismem;
        logic   trapx;
        logic   done = 1'b0;
        op_num++;
        ALU_resultM = addr;
        w_dataM     = wd;
        rdM         = rd;
        pcplus4M    = 32'h1000 + op_num * 4;
        reg_writeM  = rw;
        mem_writeM  = (kind == 2);
        result_srcM = (kind == 1) ? 2'b01 : 2'b00;
        funct3M     = f3;
        ismem       = (kind != 0);
        trapx       = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trapx = ismem && (((f3 == 3'b001 || f3 == 3'b101) && addr[0]) ||
                          (f3 == 3'b010 && addr[1:0] != 2'b00));
`endif
        e.alu   = addr;
        e.rd    = rd;
        e.pc4   = pcplus4M;
        e.rsrc  = result_srcM;
        e.regw  = trapx ? 1'b0 : rw;
        e.mis   = trapx;
        e.rdata = (kind == 1 && !trapx) ? ref_load(f3, addr, rdat) : rd_hold;
        rd_hold = e.rdata;
        sb.push_back(e);

        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (mem_req) begin
                check("bus_addr",  mem_addr,  {addr[31:2], 2'b00});
                check("bus_be",    {28'h0, mem_be}, {28'h0, ref_be(f3, addr[1:0])});
                check("bus_we",    {31'h0, mem_we}, {31'h0, (kind == 2)});
                if (kind == 2) check("bus_wdata", mem_wdata, ref_wdata(f3, wd));
                if (nbus == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdat;
                end
                nbus++;
            end else begin
                check("idle_be_we", {27'h0, mem_we, mem_be}, 32'h0);
                // A stray ack while idle must be ignored.
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            st = stallM;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!st) begin
                done = 1'b1;
            end else begin
                stalls++;
                check("bubble_regw", {31'h0, reg_writeW}, 32'h0);
            end
        end
        if (!done) check("op_timeout", 32'h1, 32'h0);
        check("stall_cycles", stalls, (ismem && !trapx) ? waits + 1 : 0);
        check("bus_cycles",   nbus,   (ismem && !trapx) ? waits + 1 : 0);

        g = sb.pop_front();
        check("ALU_resultW",   ALU_resultW, g.alu);
        check("read_dataW",    read_dataW,  g.rdata);
        check("rdW",           {27'h0, rdW}, {27'h0, g.rd});
        check("pcplus4W",      pcplus4W,    g.pc4);
        check("reg_writeW",    {31'h0, reg_writeW}, {31'h0, g.regw});
        check("result_srcW",   {30'h0, result_srcW}, {30'h0, g.rsrc});
        check("misalign_errW", {31'h0, misalign_errW}, {31'h0, g.mis});
    endtask

    task automatic check_w_zero(input string tag);
        check({tag, "_alu"}, ALU_resultW, 32'h0);
        check({tag, "_rdata"}, read_dataW, 32'h0);
        check({tag, "_misc"}, {rdW, pcplus4W[26:0]}, 32'h0);
        check({tag, "_pc4hi"}, {27'h0, pcplus4W[31:27]}, 32'h0);
        check({tag, "_flags"}, {28'h0, reg_writeW, result_srcW, misalign_errW}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; ALU_resultM = '0; w_dataM = '0; rdM = '0; pcplus4M = '0;
        reg_writeM = 1'b0; mem_writeM = 1'b0; result_srcM = '0; funct3M = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_w_zero("reset");
        check("reset_req_stall", {30'h0, mem_req, stallM}, 32'h0);
        @(posedge clk); #1;

        // ADD result passes through in one cycle
        run_op(0, 3'b000, 1'b1, 32'h10, 32'h0, 5'd5, 32'h0, 0);
        // SB 0x103, ack on first BUS cycle
        run_op(2, 3'b000, 1'b0, 32'h103, 32'hAB, 5'd0, 32'h0, 0);
        // LB / LBU 0x102 with three wait cycles
        run_op(1, 3'b000, 1'b1, 32'h102, 32'h0, 5'd7, 32'h0080_0000, 3);
        run_op(1, 3'b100, 1'b1, 32'h102, 32'h0, 5'd8, 32'h0080_0000, 3);
        // Halfword and word accesses
        run_op(2, 3'b001, 1'b0, 32'h202, 32'h5555_1234, 5'd0, 32'h0, 1);
        run_op(2, 3'b010, 1'b0, 32'h200, 32'hCAFE_F00D, 5'd0, 32'h0, 0);
        run_op(1, 3'b001, 1'b1, 32'h302, 32'h0, 5'd9, 32'h8001_7FFF, 0);
        run_op(1, 3'b101, 1'b1, 32'h302, 32'h0, 5'd10, 32'h8001_7FFF, 2);
        run_op(1, 3'b001, 1'b1, 32'h300, 32'h0, 5'd11, 32'h8001_7FFF, 0);
        run_op(1, 3'b010, 1'b1, 32'h304, 32'h0, 5'd12, 32'h1234_5678, 1);
        // Store with reg_writeM set carries it through
        run_op(2, 3'b010, 1'b1, 32'h208, 32'h0BAD_CAFE, 5'd3, 32'h0, 0);
        // Misaligned LW: trapped or passed through depending on build
        run_op(1, 3'b010, 1'b1, 32'h102, 32'h0, 5'd13, 32'h8765_4321, 1);
        run_op(0, 3'b000, 1'b1, 32'h44, 32'h0, 5'd14, 32'h0, 0);

        // Random mix
        for (int i = 0; i < 24; i++) begin
            logic [2:0] f3v;
            case ($urandom_range(0, 4))
                0: f3v = 3'b000;
                1: f3v = 3'b001;
                2: f3v = 3'b010;
                3: f3v = 3'b100;
                default: f3v = 3'b101;
            endcase
            run_op($urandom_range(0, 2), f3v, 1'($urandom_range(0, 1)), $urandom,
                   $urandom, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3));
        end

        // Reset in the second BUS cycle of a load abandons it
        op_num++;
        ALU_resultM = 32'h102; rdM = 5'd6; reg_writeM = 1'b1; mem_writeM = 1'b0;
        result_srcM = 2'b01; funct3M = 3'b000; pcplus4M = 32'h2000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_bus_req", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        result_srcM = 2'b00; reg_writeM = 1'b0;
        #1;
        check("rst_req_low", {31'h0, mem_req}, 32'h0);
        check_w_zero("rst_bus");
        @(posedge clk); #1;
        check("rst_idle", {31'h0, mem_req}, 32'h0);
        rd_hold = '0;
        run_op(0, 3'b000, 1'b1, 32'h55, 32'h0, 5'd2, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
